// File: rtl/noc_traffic_gen_pkg.sv
// Shared mesh parameters, flit layout types and command record for the traffic generator.
package noc_traffic_gen_pkg;

  localparam int Noc_X_Size    = 4;
  localparam int Noc_Y_Size    = 4;
  localparam int Coord_Width   = 4;
  localparam int Len_Width     = 6;
  localparam int Seq_Width     = 8;
  localparam int Idx_Width     = 6;
  localparam int Payload_Width = 16;

  typedef logic [Coord_Width-1:0] coord_t;
  typedef logic [Len_Width-1:0]   len_t;
  typedef logic [Seq_Width-1:0]   seq_t;
  typedef logic [Idx_Width-1:0]   idx_t;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } gen_state_e;

  // Queued packet request.
  typedef struct packed {
    coord_t dst_x;
    coord_t dst_y;
    len_t   len;
  } pkt_cmd_t;

  // HEAD / SINGLE flit: routing information plus source stamp.
  typedef struct packed {
    flit_type_e ftype;
    coord_t     dst_x;
    coord_t     dst_y;
    coord_t     src_x;
    coord_t     src_y;
    seq_t       seq;
    len_t       len;
  } head_flit_t;

  // BODY / TAIL flit: sequence, position and a checkable payload.
  typedef struct packed {
    flit_type_e                 ftype;
    seq_t                       seq;
    idx_t                       idx;
    logic [Payload_Width-1:0]   payload;
  } body_flit_t;

  // True when the coordinate lies inside the mesh.
  function automatic logic dst_in_mesh(input coord_t x, input coord_t y);
    return (int'(x) < Noc_X_Size) && (int'(y) < Noc_Y_Size);
  endfunction

endpackage

// File: rtl/noc_cmd_fifo.sv
// Show-ahead synchronous command FIFO; head entry is visible whenever empty is low.
module noc_cmd_fifo
  import noc_traffic_gen_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic     noc_clk,
  input  logic     noc_rst_n,
  input  logic     push,
  input  pkt_cmd_t push_data,
  input  logic     pop,
  output pkt_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int Ptr_Width = $clog2(Depth);
  typedef logic [Ptr_Width:0] ptr_t;

  pkt_cmd_t mem [Depth];
  ptr_t     wr_ptr;
  ptr_t     rd_ptr;
  logic     do_push;
  logic     do_pop;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[Ptr_Width] != rd_ptr[Ptr_Width]) &&
                    (wr_ptr[Ptr_Width-1:0] == rd_ptr[Ptr_Width-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[Ptr_Width-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Entry storage write.
  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge noc_clk) begin
    if (do_push) mem[wr_ptr[Ptr_Width-1:0]] <= push_data;
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node packet injector: queues requests, serialises them into HEAD/BODY/TAIL flits.
module noc_traffic_gen
  import noc_traffic_gen_pkg::*;
#(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int Cmd_Depth  = 4,
  parameter int Flit_Width = 32
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_dst_x,
  input  logic [3:0]            req_dst_y,
  input  logic [5:0]            req_len,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [Flit_Width-1:0] flit_data,
  output logic                  busy,
  output logic                  err_drop,
  output logic [15:0]           sent_pkt_cnt
);

  gen_state_e state;
  gen_state_e state_next;

  pkt_cmd_t   fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       load_cmd;
  logic       ready_en;

  coord_t     cur_dst_x;
  coord_t     cur_dst_y;
  len_t       cur_len;
  idx_t       flit_idx;
  seq_t       pkt_seq;

  logic       flit_fire;
  logic       last_flit;
  flit_type_e flit_type;
  head_flit_t head_flit;
  body_flit_t body_flit;
  logic       dst_bad;

  // ready_en keeps req_ready low while reset is asserted.
  assign req_ready = ready_en && !fifo_full;

  noc_cmd_fifo #(
    .Depth (Cmd_Depth)
  ) u_cmd_fifo (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .push      (req_valid && req_ready),
    .push_data ('{dst_x: req_dst_x, dst_y: req_dst_y, len: req_len}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dst_bad = !dst_in_mesh(fifo_head.dst_x, fifo_head.dst_y) ||
                   ((fifo_head.dst_x == coord_t'(X_ID)) && (fifo_head.dst_y == coord_t'(Y_ID)));

  assign flit_valid = (state == ST_SEND);
  assign flit_fire  = flit_valid && flit_ready;
  assign last_flit  = (flit_idx == cur_len - len_t'(1));
  assign err_drop   = (state == ST_DROP);
  assign busy       = !fifo_empty || (state != ST_IDLE);

  // Next-state decode: pop the head command in IDLE and classify it.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_next = state;
    fifo_pop   = 1'b0;
    load_cmd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_cmd   = 1'b1;
          state_next = dst_bad ? ST_DROP : ST_SEND;
        end
      end
      ST_SEND: begin
        if (flit_fire && last_flit) state_next = ST_IDLE;
      end
      ST_DROP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, command latch, flit index and packet counters.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state        <= ST_IDLE;
      ready_en     <= 1'b0;
      cur_dst_x    <= '0;
      cur_dst_y    <= '0;
      cur_len      <= '0;
      flit_idx     <= '0;
      pkt_seq      <= '0;
      sent_pkt_cnt <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (load_cmd) begin
        cur_dst_x <= fifo_head.dst_x;
        cur_dst_y <= fifo_head.dst_y;
        cur_len   <= (fifo_head.len == '0) ? len_t'(1) : fifo_head.len;
        flit_idx  <= '0;
      end else if (flit_fire) begin
        if (last_flit) begin
          pkt_seq      <= pkt_seq + seq_t'(1);
          sent_pkt_cnt <= sent_pkt_cnt + 16'd1;
        end else begin
          flit_idx <= flit_idx + idx_t'(1);
        end
      end
    end
  end

  // Flit formatter; all fields come from registers so the word holds during stalls.
  assign flit_type = (cur_len == len_t'(1)) ? FLIT_SINGLE :
                     (flit_idx == '0)       ? FLIT_HEAD   :
                     last_flit              ? FLIT_TAIL   : FLIT_BODY;

  assign head_flit = '{ftype: flit_type, dst_x: cur_dst_x, dst_y: cur_dst_y,
                       src_x: coord_t'(X_ID), src_y: coord_t'(Y_ID),
                       seq: pkt_seq, len: cur_len};

  assign body_flit = '{ftype: flit_type, seq: pkt_seq, idx: flit_idx,
                       payload: {pkt_seq, 2'b00, flit_idx}};

  assign flit_data = !flit_valid ? '0 :
                     ((flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE)) ? head_flit :
                     body_flit;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed self-checking bench for noc_traffic_gen (node at X=2, Y=1 in a 4x4 mesh).
module tb_noc_traffic_gen;

  localparam int X_ID = 2;
  localparam int Y_ID = 1;

  logic        noc_clk    = 1'b0;
  logic        noc_rst_n  = 1'b0;
  logic        req_valid  = 1'b0;
  logic [3:0]  req_dst_x  = '0;
  logic [3:0]  req_dst_y  = '0;
  logic [5:0]  req_len    = '0;
  logic        flit_ready = 1'b0;
  logic        req_ready;
  logic        flit_valid;
  logic [31:0] flit_data;
  logic        busy;
  logic        err_drop;
  logic [15:0] sent_pkt_cnt;

  noc_traffic_gen #(
    .X_ID       (X_ID),
    .Y_ID       (Y_ID),
    .Cmd_Depth  (4),
    .Flit_Width (32)
  ) dut (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dst_x    (req_dst_x),
    .req_dst_y    (req_dst_y),
    .req_len      (req_len),
    .flit_valid   (flit_valid),
    .flit_ready   (flit_ready),
    .flit_data    (flit_data),
    .busy         (busy),
    .err_drop     (err_drop),
    .sent_pkt_cnt (sent_pkt_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          drop_cycles = 0;
  logic [31:0] fq [$];
  int          tq [$];

  // Record every handshaken flit (with its cycle) and every err_drop cycle.
  always @(negedge noc_clk) begin
    cyc++;
    if (flit_valid && flit_ready) begin
      fq.push_back(flit_data);
      tq.push_back(cyc);
    end
    if (err_drop) drop_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge noc_clk);
    #1;
  endtask

  // Hold a request until it is accepted; returns just after the accept edge.
  task automatic send_req(input logic [3:0] dx, input logic [3:0] dy, input logic [5:0] len);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_dst_x = dx;
    req_dst_y = dy;
    req_len   = len;
    while (!req_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!req_ready) check("req_accept_timeout", 32'd0, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while (busy && w < budget) begin
      step();
      w++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    fq.delete();
    tq.delete();
  endtask

  function automatic logic [31:0] fq_at(input int i);
    if (i < fq.size()) return fq[i];
    return 'x;
  endfunction

  function automatic int tq_at(input int i);
    if (i < tq.size()) return tq[i];
    return -1000;
  endfunction

  function automatic logic [31:0] head_f(input logic [1:0] t, input logic [3:0] dx,
                                         input logic [3:0] dy, input logic [7:0] seq,
                                         input logic [5:0] len);
    return {t, dx, dy, 4'(X_ID), 4'(Y_ID), seq, len};
  endfunction

  function automatic logic [31:0] body_f(input logic [1:0] t, input logic [7:0] seq,
                                         input logic [5:0] idx);
    return {t, seq, idx, seq, 2'b00, idx};
  endfunction

  logic [31:0] exp_flits [4];
  logic        pat [4];
  logic        rdy_seen [5];
  int          nhs;

  initial begin
    // ---------------- reset state ----------------
    step(3);
    check("rst_flit_valid", 32'(flit_valid), 32'd0);
    check("rst_flit_data", flit_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_drop", 32'(err_drop), 32'd0);
    check("rst_sent_cnt", 32'(sent_pkt_cnt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    noc_rst_n = 1'b1;
    step(2);
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // ---------------- basic 3-flit packet ----------------
    flit_ready = 1'b1;
    clear_log();
    send_req(4'd1, 4'd0, 6'd3);
    check("t1_valid_at_accept", 32'(flit_valid), 32'd0);
    check("t1_busy_at_accept", 32'(busy), 32'd1);
    step();
    check("t1_valid_next_edge", 32'(flit_valid), 32'd1);
    check("t1_head_live", flit_data, 32'h0408_4003);
    wait_idle(20);
    check("t1_flit_count", fq.size(), 32'd3);
    check("t1_head", fq_at(0), 32'h0408_4003);
    check("t1_body", fq_at(1), 32'h4001_0001);
    check("t1_tail", fq_at(2), 32'h8002_0002);
    check("t1_sent_cnt", 32'(sent_pkt_cnt), 32'd1);

    // ---------------- len 0 and len 1 -> SINGLE ----------------
    clear_log();
    send_req(4'd0, 4'd3, 6'd0);
    send_req(4'd3, 4'd3, 6'd1);
    wait_idle(40);
    check("t2_flit_count", fq.size(), 32'd2);
    check("t2_single_len0", fq_at(0), head_f(2'b11, 4'd0, 4'd3, 8'd1, 6'd1));
    check("t2_single_len1", fq_at(1), head_f(2'b11, 4'd3, 4'd3, 8'd2, 6'd1));
    check("t2_sent_cnt", 32'(sent_pkt_cnt), 32'd3);

    // ---------------- backpressure, len 4, seq 3 ----------------
    clear_log();
    exp_flits[0] = head_f(2'b00, 4'd3, 4'd0, 8'd3, 6'd4);
    exp_flits[1] = body_f(2'b01, 8'd3, 6'd1);
    exp_flits[2] = body_f(2'b01, 8'd3, 6'd2);
    exp_flits[3] = body_f(2'b10, 8'd3, 6'd3);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    flit_ready = 1'b0;
    send_req(4'd3, 4'd0, 6'd4);
    nhs = 0;
    for (int i = 0; i < 40 && nhs < 4; i++) begin
      flit_ready = pat[i % 4];
      if (flit_valid) check($sformatf("t3_data_hs%0d_cyc%0d", nhs, i), flit_data, exp_flits[nhs]);
      if (flit_valid && flit_ready) nhs++;
      step();
    end
    check("t3_handshakes", nhs, 32'd4);
    flit_ready = 1'b1;
    wait_idle(20);
    check("t3_flit_count", fq.size(), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_logged%0d", i), fq_at(i), exp_flits[i]);
    check("t3_sent_cnt", 32'(sent_pkt_cnt), 32'd4);

    // ---------------- fill FIFO behind a stalled packet ----------------
    clear_log();
    flit_ready = 1'b0;
    send_req(4'd1, 4'd1, 6'd1);            // packet A, seq 4, held in SEND
    step();
    check("t4_a_stalled", 32'(flit_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_dst_x = (k == 4) ? 4'd2 : 4'(k % 4);
      req_dst_y = (k == 4) ? 4'd2 : 4'd2;
      req_len   = 6'd2;
      rdy_seen[k] = req_ready;
      step();
    end
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++)
      check($sformatf("t4_req_ready%0d", k), 32'(rdy_seen[k]), (k < 4) ? 32'd1 : 32'd0);
    check("t4_ready_low_full", 32'(req_ready), 32'd0);
    flit_ready = 1'b1;
    wait_idle(100);
    check("t4_flit_count", fq.size(), 32'd9);
    check("t4_a_single", fq_at(0), head_f(2'b11, 4'd1, 4'd1, 8'd4, 6'd1));
    for (int p = 0; p < 4; p++) begin
      check($sformatf("t4_head%0d", p), fq_at(1 + 2 * p),
            head_f(2'b00, 4'(p), 4'd2, 8'(5 + p), 6'd2));
      check($sformatf("t4_tail%0d", p), fq_at(2 + 2 * p), body_f(2'b10, 8'(5 + p), 6'd1));
    end
    for (int i = 1; i < 9; i++)
      check($sformatf("t4_gap%0d", i), tq_at(i) - tq_at(i - 1), (i % 2 == 1) ? 32'd2 : 32'd1);
    check("t4_sent_cnt", 32'(sent_pkt_cnt), 32'd9);

    // ---------------- dropped requests ----------------
    clear_log();
    drop_cycles = 0;
    send_req(4'd2, 4'd1, 6'd2);            // own coordinates
    wait_idle(20);
    send_req(4'd4, 4'd0, 6'd1);            // dst_x == Noc_X_Size
    wait_idle(20);
    step(2);
    check("t5_drop_cycles", drop_cycles, 32'd2);
    check("t5_no_flits", fq.size(), 32'd0);
    check("t5_sent_unchanged", 32'(sent_pkt_cnt), 32'd9);
    send_req(4'd0, 4'd0, 6'd1);
    wait_idle(20);
    check("t5_next_seq", fq_at(0), head_f(2'b11, 4'd0, 4'd0, 8'd9, 6'd1));

    // ---------------- reset mid-packet, then sequence wrap ----------------
    clear_log();
    send_req(4'd1, 4'd0, 6'd5);
    step(2);
    check("t6_in_body", flit_data, body_f(2'b01, 8'd10, 6'd1));
    noc_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(flit_valid), 32'd0);
    check("t6_rst_data", flit_data, 32'd0);
    check("t6_rst_sent", 32'(sent_pkt_cnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    step(2);
    noc_rst_n = 1'b1;
    step(2);
    clear_log();
    send_req(4'd1, 4'd0, 6'd1);
    wait_idle(20);
    check("t6_seq_restart", fq_at(0), head_f(2'b11, 4'd1, 4'd0, 8'd0, 6'd1));
    for (int i = 0; i < 256; i++) send_req(4'd1, 4'd0, 6'd1);
    wait_idle(2000);
    check("t6_wrap_count", fq.size(), 32'd257);
    check("t6_seq_255", fq_at(255), head_f(2'b11, 4'd1, 4'd0, 8'd255, 6'd1));
    check("t6_seq_wrap", fq_at(256), head_f(2'b11, 4'd1, 4'd0, 8'd0, 6'd1));
    check("t6_sent_cnt", 32'(sent_pkt_cnt), 32'd257);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
